count_enable_gen: RTL

Upstream control stage that generates the `enable` input of the 4-bit counter from a raw, bouncing push-button. The block synchronises and debounces the button, then runs a two-state run/idle machine. Button behaviour is either hold-to-run or press-to-toggle. While running, a prescaler emits `enable` once every PRESCALE cycles, so the counter advances at a controlled rate. All outputs are registered and are suitable for direct property checking.

---
 rtl/count_enable_pkg.sv | 16 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/count_enable_props.sv | 38 +++
 rtl/count_enable_gen.sv | 92 +++++++++
 4 files changed

// File: rtl/count_enable_pkg.sv
// Shared types and defaults for the counter enable generator.
package count_enable_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned PRESCALE_DEF        = 3;

  localparam logic MODE_HOLD   = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer; reports the debounced level and a
// single-cycle press strobe on each accepted 0->1 transition.
module btn_debounce
  import count_enable_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_stable,
  output logic press
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DBW-1:0]         db_cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the raw button level through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing
  // samples. press is registered at the same edge btn_stable rises, so it
  // is high exactly in the first cycle that btn_stable reads 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_stable <= 1'b0;
      db_cnt     <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        btn_stable <= sync;
        db_cnt     <= '0;
        press      <= sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_enable_props.sv
// Checks on the generator outputs, instantiated alongside each block.
module count_enable_props
  import count_enable_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEF
) (
  input logic clk,
  input logic reset,
  input logic btn_stable,
  input logic running,
  input logic enable
);

  logic        seen;
  logic [31:0] gap;

  // Count cycles since the last enable pulse, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen <= 1'b0;
      gap  <= '0;
    end else if (enable) begin
      seen <= 1'b1;
      gap  <= '0;
    end else if (gap != '1) begin
      gap <= gap + 32'd1;
    end
  end

  a_enable_implies_running : assert property (@(posedge clk) enable |-> running);

  a_enable_spacing : assert property (@(posedge clk) disable iff (reset)
    (enable && seen) |-> ((gap + 32'd1) >= PRESCALE));

  a_reset_clears : assert property (@(posedge clk)
    reset |=> (!enable && !running && !btn_stable));

endmodule

// File: rtl/count_enable_gen.sv
// Counter enable generator: debounced button drives a run/idle FSM, and a
// prescaler emits one enable pulse per PRESCALE cycles while running.
module count_enable_gen
  import count_enable_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PRESCALE        = PRESCALE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic mode,
  output logic btn_stable,
  output logic running,
  output logic enable
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  state_t        state;
  state_t        state_next;
  logic          press;
  logic [PW-1:0] pre_cnt;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_stable (btn_stable),
    .press      (press)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: hold-to-run follows the level, toggle mode flips on press.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mode == MODE_TOGGLE) begin
          if (press) state_next = RUN;
        end else begin
          if (btn_stable) state_next = RUN;
        end
      end
      RUN: begin
        if (mode == MODE_TOGGLE) begin
          if (press) state_next = IDLE;
        end else begin
          if (!btn_stable) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler: free-runs modulo PRESCALE in RUN, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (state == RUN) begin
      pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
    end else begin
      pre_cnt <= '0;
    end
  end

  // Registered outputs; enable requires staying in RUN so no pulse
  // escapes on the edge that leaves RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      enable  <= 1'b0;
    end else begin
      running <= (state_next == RUN);
      enable  <= (state == RUN) && (state_next == RUN) && (pre_cnt == PRE_MAX);
    end
  end

endmodule
